// File: rtl/arm_isa_pkg.sv
// rtl/arm_isa_pkg.sv - shared ARM-subset encodings and encoder state type
//
// Purpose: opcode, data-processing command and condition constants shared by
// the instruction encoder and the legality checker, plus the encoder FSM
// state type and a helper that packs instruction fields into a word.
// Ports: none (package).

package arm_isa_pkg;

  // Op field, instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Data-processing cmd, Funct[4:1]
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  // Memory P,U,B,W bits, Funct[4:1]: pre-indexed, add offset, word, no writeback
  localparam logic [3:0] MEM_PUBW = 4'b1100;

  localparam logic [3:0] COND_AL = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ERR   = 2'd2,
    ST_FULL  = 2'd3
  } enc_state_t;

  // Instruction word is a plain concatenation of the fields; for branches the
  // low 24 bits {Funct[3:0], Rn, Rd, Src2} form imm24 without any reshuffle.
  function automatic logic [31:0] pack_word(
    input logic [3:0]  cond,
    input logic [1:0]  op,
    input logic [5:0]  funct,
    input logic [3:0]  rn,
    input logic [3:0]  rd,
    input logic [11:0] src2
  );
    return {cond, op, funct, rn, rd, src2};
  endfunction

endpackage

// File: rtl/instr_legal_check.sv
// rtl/instr_legal_check.sv - combinational legality check for the ARM subset
//
// Purpose: flags whether an (Op, Funct) pair belongs to the subset the
// single-cycle decoder supports.
// Ports:
//   op_i     in  2  instr[27:26]
//   funct_i  in  6  instr[25:20]
//   legal_o  out 1  1 when the instruction is supported

module instr_legal_check
  import arm_isa_pkg::*;
(
  input  logic [1:0] op_i,
  input  logic [5:0] funct_i,
  output logic       legal_o
);

  logic [3:0] cmd;
  assign cmd = funct_i[4:1];

  always_comb begin
    legal_o = 1'b0;
    unique case (op_i)
      OP_DP: begin
        // CMP is only meaningful with S set, since it writes nothing but flags
        legal_o = (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
                  (cmd == CMD_AND) || (cmd == CMD_ORR) ||
                  ((cmd == CMD_CMP) && funct_i[0]);
      end
      OP_MEM:  legal_o = (cmd == MEM_PUBW);
      OP_BR:   legal_o = funct_i[5];
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_instr_encoder.sv
// rtl/arm_instr_encoder.sv - field-level ARM-subset encoder writing instruction memory
//
// Purpose: accepts instruction field bundles over valid/ready, rejects
// illegal ones with an err pulse, and writes legal words sequentially into
// instruction memory until DEPTH words are loaded.
// Ports:
//   clk         in  1         rising-edge clock
//   reset       in  1         synchronous active-low reset
//   in_valid    in  1         field bundle valid
//   in_ready    out 1         encoder can accept a bundle (IDLE only)
//   cond/Op/Funct/Rn/Rd/Src2  instruction fields, instr[31:0] high to low
//   clear       in  1         rewind address/count to 0 (IDLE and FULL only)
//   imem_we     out 1         instruction-memory write strobe
//   imem_addr   out ADDR_W    word address of the current write
//   imem_wdata  out 32        encoded instruction word
//   err         out 1         one-cycle pulse on an illegal bundle
//   full        out 1         DEPTH words written
//   count       out ADDR_W+1  words written since reset or clear

module arm_instr_encoder
  import arm_isa_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        cond,
  input  logic [1:0]        Op,
  input  logic [5:0]        Funct,
  input  logic [3:0]        Rn,
  input  logic [3:0]        Rd,
  input  logic [11:0]       Src2,
  input  logic              clear,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  enc_state_t        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic              err_q;
  logic              full_q;
  logic              legal;

  instr_legal_check u_legal (
    .op_i    (Op),
    .funct_i (Funct),
    .legal_o (legal)
  );

  assign count_d = count_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      we_q  <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // clear wins over a simultaneous bundle, which is then not taken
          if (clear) begin
            addr_q  <= '0;
            count_q <= '0;
          end else if (in_valid) begin
            if (legal) begin
              wdata_q <= pack_word(cond, Op, Funct, Rn, Rd, Src2);
              we_q    <= 1'b1;
              state_q <= ST_WRITE;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_ERR;
            end
          end
        end
        ST_WRITE: begin
          addr_q  <= addr_q + 1'b1;
          count_q <= count_d;
          if (count_d == DEPTH_C) begin
            full_q  <= 1'b1;
            state_q <= ST_FULL;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ERR: begin
          state_q <= ST_IDLE;
        end
        ST_FULL: begin
          if (clear) begin
            addr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Reset gates the strobe in the same cycle so a WRITE interrupted by reset
  // never commits; it also holds in_ready low through the reset cycle.
  assign imem_we    = we_q & reset;
  assign in_ready   = (state_q == ST_IDLE) & reset;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign err        = err_q;
  assign full       = full_q;
  assign count      = count_q;

endmodule
